ram_access_sequencer: RTL and testbench
=======================================

# ram_access_sequencer

Sequencer and round-robin arbiter that shares the single-port SPI-slave RAM between `NUM_REQ` requesters. It converts each granted read or write transaction into the RAM's two-command `din[9:0]`/`rx_valid` protocol (`WRITE_ADDRESS`→`WRITE_DATA`, or `READ_ADDRESS`→`READ_DATA`). For reads it collects `dout` on `tx_valid`. It sits between the requester ports (SPI slave, host/DMA) and the RAM's command inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `TIMEOUT_CYCLES`, 15: maximum cycles to wait in WAIT_RD; used only when `RAM_SEQ_TIMEOUT_EN` is defined.

- `clk`  in  1  the single clock. All logic is rising-edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  NUM_REQ  per-requester request level.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*8  packed addresses; requester i uses `[8i+7:8i]`.
- `req_wdata`  in  NUM_REQ*8  packed write data.
- `ack`  out  NUM_REQ  one-hot, single-cycle completion pulse.
- `rdata`  out  8  read data, valid in the `ack` cycle. Otherwise it holds its last value.
- `rd_err`  out  1  read timed out, valid in the `ack` cycle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `ram_din`  out  10  RAM command word `{opcode[1:0], payload[7:0]}`.
- `ram_rx_valid`  out  1  RAM command strobe.
- `ram_dout`  in  8  RAM read data.
- `ram_tx_valid`  in  1  RAM read-data valid.

## Operation
- **Reset.**
  - `ack`, `rdata`, `rd_err`, `busy`, `ram_din` and `ram_rx_valid` all reset to 0.
  - The state resets to IDLE and the priority pointer resets to 0.
  - The timeout counter resets to 0.
- **IDLE**
  - If any `req` bit is high, pick winner g by round-robin, starting at the priority pointer.
  - Latch `req_we[g]`, `req_addr[g]` and `req_wdata[g]`, then go to ADDR.
  - Requester inputs are sampled only in this cycle.
- **ADDR**
  - `ram_rx_valid`=1.
  - `ram_din` = {`WRITE_ADDRESS`, addr} for a write, or {`READ_ADDRESS`, addr} for a read.
  - Go to DATA.
- **DATA**
  - `ram_rx_valid`=1.
  - `ram_din` = {`WRITE_DATA`, wdata} for a write, or {`READ_DATA`, 8'h00} for a read.
  - A write goes to DONE; a read goes to WAIT_RD.
- **WAIT_RD**
  - `ram_rx_valid`=0.
  - On `ram_tx_valid`=1, register `ram_dout` into `rdata` and go to DONE.
  - `ram_tx_valid` is ignored in every other state.
- **DONE**
  - `ack[g]`=1 for exactly one cycle.
  - Set priority pointer = (g+1) mod NUM_REQ, then go to IDLE.
- **Request handshake.**
  - Each requester holds `req` until it sees its `ack`.
  - If `req[g]` is still high in the IDLE that follows DONE, it is treated as a new transaction.
  - The round-robin order guarantees another pending requester wins first.
- **Command bus.**
  - `ram_din` is 0 whenever `ram_rx_valid`=0.
  - Exactly two command cycles are issued per transaction, always back-to-back.
- **Reset mid-transaction.** The transaction is dropped with no `ack`, and `ram_rx_valid` falls immediately (asynchronously).
- **Invalid requests.** Requests whose bit index is ≥ `NUM_REQ` are not possible. A `req` that drops before grant is simply not served.

## Timing
- All outputs are registered.
- Timeline for a request seen in IDLE at cycle N:
  - ADDR at N+1 and DATA at N+2.
  - A write acks at N+3.
  - A read enters WAIT_RD at N+3. The RAM raises `tx_valid` at N+3 at the earliest, giving `ack` at N+4 at the earliest.
- Back-to-back throughput: a new transaction can start at DONE+1. The minimum period is 4 cycles for writes and 5 for reads.
- `busy` is high from N+1 through the DONE cycle.

## Configuration
- **Macro `RAM_SEQ_TIMEOUT_EN` defined:**
  - A 4-bit-minimum counter runs in WAIT_RD.
  - After `TIMEOUT_CYCLES` cycles without `ram_tx_valid`, the block goes to DONE with `rd_err`=1 and `rdata`=8'h00.
  - The counter clears on entry to WAIT_RD.
- **Macro not defined:**
  - WAIT_RD waits indefinitely.
  - `rd_err` is tied to 0 and no counter logic exists.

## Structure
- Shared package `ram_pkg`:
  - Already provides the opcodes `WRITE_ADDRESS`=2'b00, `WRITE_DATA`=2'b01, `READ_ADDRESS`=2'b10, `READ_DATA`=2'b11.
  - Add the state enum `ram_seq_state_e` {IDLE, ADDR, DATA, WAIT_RD, DONE}.
- Sub-module `ram_rr_pick`: combinational round-robin pick over `req` and the pointer. It returns a one-hot grant and its index.

## Test plan
- **Write:** req[0]=1, we=1, addr=8'h3C, wdata=8'hA5.
  - N+1: `ram_din`=10'h03C, rx_valid=1.
  - N+2: `ram_din`=10'h1A5.
  - N+3: ack=2'b01.
- **Read:** req[1]=1, we=0, addr=8'h3C; RAM returns 8'hA5 one cycle after READ_DATA.
  - `ram_din` is 10'h23C, then 10'h300.
  - ack=2'b10 and rdata=8'hA5 at N+4.
- **Contention:** req=2'b11 held continuously. Grants alternate 0,1,0,1 with no requester served twice in a row.
- **Timeout (macro on):** read with `ram_tx_valid` never asserted. ack and rd_err=1 arrive after 15 WAIT_RD cycles, with rdata=0.
- **Timeout (macro off):** the same stimulus leaves `busy` high indefinitely.
- **Reset mid-DATA:** assert rst. Next edge shows rx_valid=0, ack=0, busy=0 and IDLE; a fresh request then completes normally.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: RAM command opcodes and sequencer types
// shared by the RAM access path
package ram_pkg;

  localparam logic [1:0] WRITE_ADDRESS = 2'b00;
  localparam logic [1:0] WRITE_DATA    = 2'b01;
  localparam logic [1:0] READ_ADDRESS  = 2'b10;
  localparam logic [1:0] READ_DATA     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RD,
    DONE
  } ram_seq_state_e;

  function automatic logic [9:0] ram_cmd(
    input logic [1:0] op,
    input logic [7:0] pl
  );
    return {op, pl};
  endfunction

endpackage

// File: rtl/ram_rr_pick.sv
// ram_rr_pick: combinational round-robin pick
// first active request at or after ptr, wrapping
module ram_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // scan from farthest to nearest so the nearest to ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: round-robin sharing of the SPI-slave RAM.
// Optional WAIT_RD timeout: define RAM_SEQ_TIMEOUT_EN.
module ram_access_sequencer
  import ram_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [NUM_REQ*8-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           rdata,
  output logic                 rd_err,
  output logic                 busy,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_cfg_bad
    $error("ram_access_sequencer: unsupported parameters");
  end

  ram_seq_state_e state, state_n;

  logic [IW-1:0]      ptr, ptr_n, gidx, pick_idx;
  logic [NUM_REQ-1:0] gnt_q, pick_gnt, ack_n;
  logic               we_q, sel_we;
  logic [7:0]         addr_q, wdata_q;
  logic [7:0]         sel_addr, sel_wdata, rdata_n;
  logic [9:0]         din_n;
  logic               rxv_n, rdata_ld;

`ifdef RAM_SEQ_TIMEOUT_EN
  localparam int CWR = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CWR > 4) ? CWR : 4;
  logic [CW-1:0] cnt;
  logic          err_n;
`endif

  ram_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // route the winning requester's fields
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[8*i +: 8];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // next state plus next values of the registered outputs
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    din_n    = '0;
    rxv_n    = 1'b0;
    ack_n    = '0;
    rdata_ld = 1'b0;
    rdata_n  = rdata;
`ifdef RAM_SEQ_TIMEOUT_EN
    err_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = ADDR;
          rxv_n   = 1'b1;
          din_n   = ram_cmd(sel_we ? WRITE_ADDRESS
                                   : READ_ADDRESS, sel_addr);
        end
      end
      ADDR: begin
        state_n = DATA;
        rxv_n   = 1'b1;
        din_n   = we_q ? ram_cmd(WRITE_DATA, wdata_q)
                       : ram_cmd(READ_DATA, 8'h00);
      end
      DATA: begin
        if (we_q) begin
          state_n = DONE;
          ack_n   = gnt_q;
        end else begin
          state_n = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          state_n  = DONE;
          ack_n    = gnt_q;
          rdata_ld = 1'b1;
          rdata_n  = ram_dout;
        end
`ifdef RAM_SEQ_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n  = DONE;
          ack_n    = gnt_q;
          rdata_ld = 1'b1;
          rdata_n  = 8'h00;
          err_n    = 1'b1;
        end
`endif
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = (gidx == IW'(NUM_REQ - 1)) ? '0
                                             : gidx + IW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // state, grant capture and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      gidx         <= '0;
      gnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack          <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      ack          <= ack_n;
      busy         <= (state_n != IDLE);
      ram_din      <= din_n;
      ram_rx_valid <= rxv_n;
      if (rdata_ld) begin
        rdata <= rdata_n;
      end
      if (state == IDLE && |req) begin
        gidx    <= pick_idx;
        gnt_q   <= pick_gnt;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

`ifdef RAM_SEQ_TIMEOUT_EN
  // wait counter restarts on every WAIT_RD entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rd_err <= 1'b0;
    end else begin
      cnt    <= (state == WAIT_RD) ? cnt + CW'(1) : '0;
      rd_err <= err_n;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer: random + directed bench with a
// transaction-level model of the RAM sequencer.
`timescale 1ns/1ps
module tb_ram_access_sequencer;

  localparam int NUM_REQ = 2;
  localparam int TO      = 15;
  localparam int NO_RESP = 99;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ-1:0]   req_we = '0;
  logic [NUM_REQ*8-1:0] req_addr = '0;
  logic [NUM_REQ*8-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           rdata;
  logic                 rd_err;
  logic                 busy;
  logic [9:0]           ram_din;
  logic                 ram_rx_valid;
  logic [7:0]           ram_dout = '0;
  logic                 ram_tx_valid = 1'b0;

  ram_access_sequencer #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .rdata        (rdata),
    .rd_err       (rd_err),
    .busy         (busy),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit         r_req [NUM_REQ];
  bit         r_we  [NUM_REQ];
  logic [7:0] r_addr[NUM_REQ];
  logic [7:0] r_wd  [NUM_REQ];
  bit         rand_en = 0;
  bit         keep = 0;
  int         force_d = -1;
  bit         force_dout_en = 0;
  logic [7:0] force_dout = '0;

  bit         m_act = 0;
  bit         m_we, m_to, just_done;
  int         m_n, m_g, m_ackrel, m_d;
  int         m_ptr = 0;
  logic [7:0] m_addr, m_wd, m_dout;
  logic [7:0] m_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic bit any_req();
    bit a = 0;
    for (int i = 0; i < NUM_REQ; i++) a |= r_req[i];
    return a;
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]             = r_req[i];
      req_we[i]          = r_we[i];
      req_addr[8*i +: 8] = r_addr[i];
      req_wdata[8*i +: 8] = r_wd[i];
    end
  endtask

  task automatic new_params(input int i);
    r_we[i]   = 1'($urandom_range(0, 1));
    r_addr[i] = 8'($urandom);
    r_wd[i]   = 8'($urandom);
  endtask

  task automatic reset_model();
    m_act     = 0;
    m_ptr     = 0;
    m_rdata   = '0;
    just_done = 0;
    for (int i = 0; i < NUM_REQ; i++) r_req[i] = 0;
    drive_req();
  endtask

  // expected outputs for the current cycle, from transaction timing
  task automatic compare();
    int rel;
    logic [9:0] e_din;
    logic [NUM_REQ-1:0] e_ack;
    bit e_rxv, e_busy, e_err;
    rel    = m_act ? cyc - m_n : -1;
    e_din  = '0;
    e_ack  = '0;
    e_err  = 0;
    e_rxv  = m_act && (rel == 1 || rel == 2);
    e_busy = m_act && rel >= 1 && rel <= m_ackrel;
    if (m_act && rel == 1)
      e_din = {(m_we ? 2'b00 : 2'b10), m_addr};
    if (m_act && rel == 2)
      e_din = {(m_we ? 2'b01 : 2'b11), (m_we ? m_wd : 8'h00)};
    if (m_act && rel == m_ackrel) begin
      e_ack[m_g] = 1'b1;
      e_err      = m_to;
      if (!m_we) m_rdata = m_to ? 8'h00 : m_dout;
    end
    chk("ram_din", 32'(ram_din), 32'(e_din));
    chk("ram_rx_valid", 32'(ram_rx_valid), 32'(e_rxv));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rd_err", 32'(rd_err), 32'(e_err));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic cycle();
    int rel;
    @(posedge clk);
    #1;
    cyc++;
    compare();
    just_done = 0;
    if (m_act && cyc - m_n == m_ackrel) begin
      m_ptr     = (m_g + 1) % NUM_REQ;
      m_act     = 0;
      just_done = 1;
      if (keep || (rand_en && $urandom_range(0, 1) == 1))
        begin if (rand_en) new_params(m_g); end
      else r_req[m_g] = 0;
    end
    if (rand_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!r_req[i] && $urandom_range(0, 9) < 3) begin
          r_req[i] = 1;
          new_params(i);
        end
      end
    end
    drive_req();
    if (!m_act && !just_done && any_req()) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j = (m_ptr + k) % NUM_REQ;
        if (r_req[j] && !m_act) begin
          m_act = 1;
          m_g   = j;
        end
      end
      m_n    = cyc;
      m_we   = r_we[m_g];
      m_addr = r_addr[m_g];
      m_wd   = r_wd[m_g];
      m_to   = 0;
      m_d    = 0;
      if (m_we) m_ackrel = 3;
      else begin
        if (force_d >= 0) m_d = force_d;
        else begin
          m_d = $urandom_range(0, 3);
`ifdef RAM_SEQ_TIMEOUT_EN
          if ($urandom_range(0, 7) == 0) m_d = NO_RESP;
`endif
        end
        m_dout = force_dout_en ? force_dout : 8'($urandom);
        if (m_d == NO_RESP) begin
`ifdef RAM_SEQ_TIMEOUT_EN
          m_to     = 1;
          m_ackrel = 3 + TO;
`else
          m_ackrel = 1 << 30;
`endif
        end else m_ackrel = 4 + m_d;
      end
    end
    ram_dout     = 8'($urandom);
    ram_tx_valid = ($urandom_range(0, 3) == 0);
    if (m_act && !m_we) begin
      rel = cyc - m_n;
      if (m_d != NO_RESP && rel == 3 + m_d) begin
        ram_tx_valid = 1'b1;
        ram_dout     = m_dout;
      end else if (rel >= 3 && rel < m_ackrel) begin
        ram_tx_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((m_act || any_req()) && i < 200) begin
      cycle();
      i++;
    end
    chk("drain_timeout", 32'(m_act || any_req()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    int i;
    for (int k = 0; k < NUM_REQ; k++) begin
      r_req[k] = 0; r_we[k] = 0; r_addr[k] = '0; r_wd[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_rxv", 32'(ram_rx_valid), 32'd0);
    rst = 1'b0;
    reset_model();
    cycle();

    r_req[0] = 1; r_we[0] = 1; r_addr[0] = 8'h3C; r_wd[0] = 8'hA5;
    cycle();
    cycle();
    chk("wr_addr_din", 32'(ram_din), 32'h03C);
    chk("wr_addr_rxv", 32'(ram_rx_valid), 32'd1);
    cycle();
    chk("wr_data_din", 32'(ram_din), 32'h1A5);
    cycle();
    chk("wr_ack", 32'(ack), 32'b01);

    r_req[1] = 1; r_we[1] = 0; r_addr[1] = 8'h3C;
    force_d = 0; force_dout_en = 1; force_dout = 8'hA5;
    cycle();
    cycle();
    chk("rd_addr_din", 32'(ram_din), 32'h23C);
    cycle();
    chk("rd_data_din", 32'(ram_din), 32'h300);
    cycle();
    chk("rd_wait_ack", 32'(ack), 32'd0);
    chk("rd_wait_rxv", 32'(ram_rx_valid), 32'd0);
    cycle();
    chk("rd_ack", 32'(ack), 32'b10);
    chk("rd_rdata", 32'(rdata), 32'hA5);
    force_d = -1; force_dout_en = 0;

    keep = 1;
    for (int k = 0; k < NUM_REQ; k++) begin
      r_req[k] = 1; r_we[k] = 1; r_addr[k] = 8'(k); r_wd[k] = 8'(k + 16);
    end
    i = 0;
    while (got.size() < 4 && i < 60) begin
      cycle();
      i++;
      if (ack != '0) got.push_back(int'(ack));
    end
    keep = 0;
    chk("cont_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("cont_grant", 32'(k < got.size() ? got[k] : 0),
          32'((k % 2 == 0) ? 1 : 2));
    wait_idle();

    rand_en = 1;
    repeat (3000) cycle();
    rand_en = 0;
    wait_idle();

    force_d = NO_RESP;
    r_req[0] = 1; r_we[0] = 0; r_addr[0] = 8'h55;
    cycle();
`ifdef RAM_SEQ_TIMEOUT_EN
    i = 0;
    while (ack == '0 && i < 40) begin
      cycle();
      i++;
    end
    chk("to_latency", 32'(i), 32'd18);
    chk("to_rd_err", 32'(rd_err), 32'd1);
    chk("to_rdata", 32'(rdata), 32'd0);
    force_d = -1;
    wait_idle();
`else
    repeat (40) cycle();
    chk("noto_busy", 32'(busy), 32'd1);
    force_d = -1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    reset_model();
`endif

    r_req[1] = 1; r_we[1] = 1; r_addr[1] = 8'h77; r_wd[1] = 8'h88;
    cycle();
    cycle();
    cycle();
    chk("mid_data_rxv", 32'(ram_rx_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_rxv", 32'(ram_rx_valid), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_edge_rxv", 32'(ram_rx_valid), 32'd0);
    chk("rst_edge_ack", 32'(ack), 32'd0);
    chk("rst_edge_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    reset_model();
    r_req[0] = 1; r_we[0] = 1; r_addr[0] = 8'h12; r_wd[0] = 8'h34;
    i = 0;
    got.delete();
    while (got.size() < 1 && i < 20) begin
      cycle();
      i++;
      if (ack != '0) got.push_back(int'(ack));
    end
    chk("post_rst_ack", 32'(got.size() > 0 ? got[0] : 0), 32'b01);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
